// File: rtl/lc3b_types.sv
// Shared fetch types: FSM state encoding and the queued fetch record layout.
// Latency: n/a (types and a width helper only).
// Backpressure: n/a.
package lc3b_types;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // Canonical field order of a queue entry. The queue stores entries as a
    // flat vector in exactly this order so that any WIDTH can be carried.
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
        logic              pred_taken;
        logic [WORD_W-1:0] pred_next;
    } fetch_entry;

    function automatic int unsigned entry_bits(input int unsigned w);
        return 3 * w + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue holding {pc, instr, pred_taken, pred_next} entries.
// Latency: a push at edge k is visible at head/count right after edge k.
// Backpressure: caller never pushes when full; flush wins over push and pop.
//
// Ports: clk, reset_n (async, active-low); push/push_data write at the tail;
// pop advances the head; flush empties; head is the oldest entry; count is
// the occupancy (0..DEPTH).
module fetch_queue
    import lc3b_types::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [entry_bits(WIDTH)-1:0]   push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [entry_bits(WIDTH)-1:0]   head,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = entry_bits(WIDTH);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Storage is cleared on reset so the head fields read zero out of reset.
    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/cpu_fetch_queued.sv
// Instruction fetch unit: issues icache reads from pc and queues results for decode.
// Latency: response sampled at edge k is presented (out_valid) in cycle k+1.
// Backpressure: out_ready low lets the queue fill; fetch stops issuing when full.
//
// Ports: clk, reset_n (async, active-low); redirect/redirect_pc correct the pc
// and flush the queue; mem_read/mem_address request, mem_resp/mem_rdata
// complete; bp_pc/bp_taken/bp_target talk to an external predictor;
// out_valid/out_ready plus out_pc/out_instr/out_pred_taken/out_pred_next
// present the queue head; count is queue occupancy.
// Build option: define BRANCH_PREDICTION_EN to follow bp_taken/bp_target;
// otherwise the predictor inputs are ignored and fetch is sequential (pc+2).
module cpu_fetch_queued
    import lc3b_types::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   redirect,
    input  logic [WIDTH-1:0]       redirect_pc,
    output logic                   mem_read,
    output logic [WIDTH-1:0]       mem_address,
    input  logic                   mem_resp,
    input  logic [WIDTH-1:0]       mem_rdata,
    output logic [WIDTH-1:0]       bp_pc,
    input  logic                   bp_taken,
    input  logic [WIDTH-1:0]       bp_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_pc,
    output logic [WIDTH-1:0]       out_instr,
    output logic [WIDTH-1:0]       out_pred_next,
    output logic                   out_pred_taken,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e            state;
    fetch_state_e            state_nxt;
    logic [WIDTH-1:0]        pc;
    logic [WIDTH-1:0]        pc_nxt;
    logic [WIDTH-1:0]        next_pc;
    logic                    pred_taken;
    logic                    push;
    logic                    pop;
    logic [CW-1:0]           cnt_after_push;
    logic [entry_bits(WIDTH)-1:0] head;

`ifdef BRANCH_PREDICTION_EN
    assign pred_taken = bp_taken;
    assign next_pc    = bp_taken ? bp_target : pc + WIDTH'(2);
`else
    assign pred_taken = 1'b0;
    assign next_pc    = pc + WIDTH'(2);
    logic unused_bp;
    assign unused_bp = ^{bp_taken, bp_target};
`endif

    assign bp_pc       = pc;
    assign mem_address = pc;

    // A redirect hides the head this cycle so decode never consumes an entry
    // that is about to be flushed.
    assign out_valid = (count != '0) && !redirect;
    assign pop       = out_valid && out_ready;

    // Occupancy seen after a push this cycle; the REQ state only keeps issuing
    // while there is still room for the next response.
    assign cnt_after_push = count + CW'(1) - CW'(pop);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        mem_read  = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && (count < CW'(DEPTH))) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_read = 1'b1;
                if (redirect) begin
                    // Same-cycle response belongs to the old path: drop it.
                    state_nxt = mem_resp ? IDLE : DROP;
                end else if (mem_resp) begin
                    push      = 1'b1;
                    pc_nxt    = next_pc;
                    state_nxt = (cnt_after_push < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                // Waiting out a request issued before a redirect.
                mem_read = 1'b1;
                if (mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (redirect) begin
            pc_nxt = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= PC_RESET;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    fetch_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({pc, mem_rdata, pred_taken, next_pc}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

    assign {out_pc, out_instr, out_pred_taken, out_pred_next} = head;

endmodule

// File: tb/tb_cpu_fetch_queued.sv
// Testbench for cpu_fetch_queued: icache responder with variable latency,
// combinational predictor, and a transaction-level reference queue.
module tb_cpu_fetch_queued;

    localparam int          D   = 4;
    localparam logic [15:0] PCR = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        mem_read;
    logic [15:0] mem_address;
    logic        mem_resp = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] bp_pc;
    logic        bp_taken;
    logic [15:0] bp_target;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [15:0] out_pred_next;
    logic        out_pred_taken;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;
    int lat = 1;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] nxt;
        logic        tk;
    } ent_t;

    ent_t        q[$];
    logic [15:0] pop_pc[$];
    logic [15:0] pop_pn[$];
    logic [15:0] mfetch = PCR;
    bit          stale = 1'b0;

    cpu_fetch_queued #(.WIDTH(16), .DEPTH(D), .PC_RESET(PCR)) dut (
        .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_read(mem_read), .mem_address(mem_address), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_pred_next(out_pred_next), .out_pred_taken(out_pred_taken), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // External predictor: taken whenever the low byte of the pc is 0x04.
    function automatic logic env_taken(input logic [15:0] a);
        return a[7:0] == 8'h04;
    endfunction

    assign bp_taken  = env_taken(bp_pc);
    assign bp_target = bp_pc + 16'h003C;

    function automatic logic exp_taken(input logic [15:0] a);
`ifdef BRANCH_PREDICTION_EN
        return env_taken(a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] exp_next(input logic [15:0] a);
        return exp_taken(a) ? a + 16'h003C : a + 16'h0002;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // icache: answers the current request after lat cycles of mem_read.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                cnt = 0;
                mem_resp = 1'b0;
            end else begin
                if (mem_resp) cnt = 0;
                if (mem_read) cnt++;
                else cnt = 0;
                mem_resp  = mem_read && (cnt >= lat);
                mem_rdata = mem_resp ? instr_of(mem_address) : 16'($urandom);
            end
        end
    end

    // Check the cycle's outputs, then advance the model across the coming edge.
    task automatic sample_and_model();
        ent_t e;
        chk("bp_pc", bp_pc, mfetch);
        chk("count", count, q.size());
        chk("out_valid", out_valid, (q.size() != 0) && !redirect);
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
            chk("out_pred_next", out_pred_next, q[0].nxt);
            chk("out_pred_taken", out_pred_taken, q[0].tk);
        end
        if (mem_read) chk("mem_address", mem_address, mfetch);
        if (q.size() == D) chk("full_no_read", mem_read, 1'b0);

        if (q.size() != 0 && !redirect && out_ready) begin
            pop_pc.push_back(q[0].pc);
            pop_pn.push_back(q[0].nxt);
            q.delete(0);
        end
        if (redirect) begin
            q.delete();
            stale  = mem_read && !mem_resp;
            mfetch = redirect_pc;
        end else if (mem_resp) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                e.pc    = mfetch;
                e.instr = instr_of(mfetch);
                e.tk    = exp_taken(mfetch);
                e.nxt   = exp_next(mfetch);
                q.push_back(e);
                mfetch  = e.nxt;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample_and_model();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        redirect = 1'b0;
        #1;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, 16'h0000);
        chk("rst_out_instr", out_instr, 16'h0000);
        chk("rst_out_pred_next", out_pred_next, 16'h0000);
        chk("rst_out_pred_taken", out_pred_taken, 1'b0);
        chk("rst_bp_pc", bp_pc, PCR);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        q.delete();
        mfetch = PCR;
        stale  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          rises;
        logic        prev;
        logic [15:0] e41;

        #3;
        do_reset();

        // Sequential fetch, single-cycle icache, decode always ready.
        lat = 1;
        out_ready = 1'b1;
        pop_pc.delete();
        n = 0;
        while (pop_pc.size() < 3 && n < 40) begin tick(); n++; end
        chk("t037_wait", n < 40, 1'b1);
        if (pop_pc.size() >= 3) begin
            chk("t037_pc0", pop_pc[0], 16'h0000);
            chk("t037_pc1", pop_pc[1], 16'h0002);
            chk("t037_pc2", pop_pc[2], 16'h0004);
        end

        // Stall decode: queue fills and fetch goes quiet.
        out_ready = 1'b0;
        repeat (20) tick();
        chk("t038_full", count, 3'd4);
        chk("t038_no_read", mem_read, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rises = 0;
        prev  = mem_read;
        repeat (15) begin
            tick();
            if (mem_read && !prev) rises++;
            prev = mem_read;
        end
        chk("t038_one_request", rises, 1);
        chk("t038_refull", count, 3'd4);

        // Redirect while a 3-cycle request is outstanding.
        lat = 3;
        out_ready = 1'b1;
        n = 0;
        while (!(mem_read && !mem_resp && !stale) && n < 50) begin tick(); n++; end
        chk("t039_wait_req", n < 50, 1'b1);
        redirect = 1'b1;
        redirect_pc = 16'h1000;
        tick();
        redirect = 1'b0;
        chk("t039_flush", count, 3'd0);
        pop_pc.delete();
        n = 0;
        while (pop_pc.size() < 1 && n < 60) begin tick(); n++; end
        chk("t039_wait_pop", n < 60, 1'b1);
        if (pop_pc.size() >= 1) chk("t039_first_pc", pop_pc[0], 16'h1000);

        // Redirect in the same cycle as a response.
        lat = 2;
        n = 0;
        while (!(mem_resp && !stale) && n < 50) begin tick(); n++; end
        chk("t040_wait_resp", n < 50, 1'b1);
        redirect = 1'b1;
        redirect_pc = 16'h2000;
        tick();
        redirect = 1'b0;
        chk("t040_no_push", count, 3'd0);
        n = 0;
        while (!mem_read && n < 10) begin tick(); n++; end
        chk("t040_wait_read", n < 10, 1'b1);
        chk("t040_addr", mem_address, 16'h2000);

        // Prediction at pc 0x0004.
        lat = 1;
        redirect = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        pop_pc.delete();
        pop_pn.delete();
        n = 0;
        while (pop_pc.size() < 4 && n < 40) begin tick(); n++; end
        chk("t041_wait", n < 40, 1'b1);
`ifdef BRANCH_PREDICTION_EN
        e41 = 16'h0040;
`else
        e41 = 16'h0006;
`endif
        if (pop_pc.size() >= 4) begin
            chk("t041_pc", pop_pc[2], 16'h0004);
            chk("t041_pred_next", pop_pn[2], e41);
            chk("t041_next_pc", pop_pc[3], e41);
        end

        // Address wrap at the top of the space.
        redirect = 1'b1;
        redirect_pc = 16'hFFFC;
        tick();
        redirect = 1'b0;
        pop_pc.delete();
        n = 0;
        while (pop_pc.size() < 3 && n < 40) begin tick(); n++; end
        chk("t042_wait", n < 40, 1'b1);
        if (pop_pc.size() >= 3) begin
            chk("t042_fffe", pop_pc[1], 16'hFFFE);
            chk("t042_wrap", pop_pc[2], 16'h0000);
        end

        // Random traffic, including one reset mid-stream.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            out_ready   = ($urandom_range(0, 3) != 0);
            lat         = $urandom_range(1, 4);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom) & 16'hFFFE;
            tick();
        end
        redirect = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_fetch_queued.md
CPU_FETCH_QUEUED -- requirements
Module: cpu_fetch_queued

Interface
REQ-001 SHALL have parameter WIDTH, default 16, instruction/address width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, instruction-queue entries; power of two, at least 2.
REQ-003 SHALL have parameter PC_RESET, default 0, PC value loaded at reset.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port redirect  in  1  and port redirect_pc  in  WIDTH; together they give the control-flow correction PC.
REQ-007 SHALL have port mem_read  out  1  and port mem_address  out  WIDTH; together they form the icache read request.
REQ-008 SHALL have port mem_resp  in  1  and port mem_rdata  in  WIDTH; together they form the icache read completion.
REQ-009 SHALL have port bp_pc  out  WIDTH; it is the current fetch PC sent to the external predictor.
REQ-010 SHALL have port bp_taken  in  1  and port bp_target  in  WIDTH; together they form the combinational prediction for bp_pc.
REQ-011 SHALL have ports out_valid  out  1  and out_ready  in  1; together they form the decode handshake.
REQ-012 SHALL have ports out_pc, out_instr, out_pred_next  out  WIDTH  and out_pred_taken  out  1; these carry the head queue entry.
REQ-013 SHALL have port count  out  $clog2(DEPTH)+1  giving the number of occupied queue entries.

Function
REQ-014 SHALL implement fetch FSM states IDLE, REQ and DROP.
REQ-015 IDLE: if count<DEPTH and !redirect, SHALL go to REQ next cycle; otherwise SHALL stay in IDLE.
REQ-016 REQ and DROP SHALL assert mem_read=1 and hold mem_address=pc stable until mem_resp; mem_read SHALL be 0 in IDLE.
REQ-017 REQ with mem_resp and !redirect SHALL push {pc, mem_rdata, pred_taken, next_pc} and load pc<=next_pc.
REQ-018 After that push, the FSM SHALL stay in REQ if post-push count<DEPTH, else go to IDLE.
REQ-019 REQ with redirect and !mem_resp SHALL load pc<=redirect_pc and go to DROP.
REQ-020 REQ with redirect and mem_resp in the same cycle SHALL discard the response, load pc<=redirect_pc and go to IDLE.
REQ-021 DROP SHALL discard mem_rdata on mem_resp and go to IDLE; a redirect in DROP SHALL reload pc and remain in DROP unless mem_resp is also asserted.
REQ-022 A redirect in any state SHALL empty the queue at the next edge; a pop in that cycle SHALL be ignored.
REQ-023 out_valid SHALL equal (count!=0) && !redirect; a pop SHALL occur on out_valid && out_ready.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 A push SHALL never be attempted when full; the REQ-015 issue rule guarantees this.
REQ-027 next_pc = pc+2 modulo 2^WIDTH when not predicted; the wrap from 0xFFFE to 0x0000 is legal.
REQ-028 Latency: response sampled at edge k SHALL give out_valid=1 in cycle k+1 when the queue was empty.
REQ-029 bp_pc SHALL equal pc at all times; bp_taken/bp_target SHALL be sampled in the mem_resp cycle.

Reset
REQ-030 On reset_n=0, without waiting for clk, the block SHALL set pc=PC_RESET, state=IDLE, count=0, all pointers 0 and mem_read=0.
REQ-031 On reset_n=0, the block SHALL set out_valid=0 and out_pc, out_instr, out_pred_next and out_pred_taken to 0.
REQ-032 Reset mid-request SHALL abandon the request; the icache is reset by the same reset_n.

Configuration
REQ-033 With BRANCH_PREDICTION_EN defined: pred_taken=bp_taken; next_pc = bp_taken ? bp_target : pc+2.
REQ-034 Without BRANCH_PREDICTION_EN: pred_taken=0 and next_pc=pc+2; bp_taken and bp_target SHALL be ignored.

Structure
REQ-035 The fetch-state enum and the fetch_entry struct {pc, instr, pred_taken, pred_next} SHALL live in package lc3b_types.
REQ-036 The queue storage and pointers SHALL be sub-module fetch_queue, parametrised by WIDTH and DEPTH, with push, pop, flush and count.

Verification
REQ-037 Reset, then 1-cycle mem_resp, out_ready=1: out_pc SHALL read 0x0000, 0x0002, 0x0004 on consecutive valid cycles.
REQ-038 out_ready=0 with DEPTH=4: count SHALL reach 4 and mem_read SHALL drop to 0; one pop SHALL issue exactly one new request.
REQ-039 Redirect to 0x1000 while in REQ with 3-cycle latency: the stale response SHALL be dropped, count SHALL be 0 and the next out_pc SHALL be 0x1000.
REQ-040 Redirect to 0x2000 coincident with mem_resp: no push SHALL occur and the next request address SHALL be 0x2000.
REQ-041 With BRANCH_PREDICTION_EN, bp_taken=1 and bp_target=0x0040 at pc 0x0004: out_pred_next SHALL be 0x0040 and the next out_pc SHALL be 0x0040.
REQ-042 With pc=0xFFFE, no prediction and no redirect: the fetch after 0xFFFE SHALL be at address 0x0000.
